// File: rtl/hazard_control_unit.sv
// -----------------------------------------------------------------------------
// hazard_control_unit
//
// Purpose:
//   Handles the pipeline hazards that the forwarding unit cannot resolve:
//   - stalls the front end for one cycle on a load-use dependence,
//   - freezes the whole pipeline while data memory is busy,
//   - flushes wrong-path instructions on a taken branch. A branch that
//     resolves during a memory freeze is remembered and flushed in a
//     dedicated cycle after the freeze ends.
//   Also keeps saturating stall/flush counters and a sticky memory-wait
//   watchdog.
//
// Parameters:
//   MAX_WAIT  consecutive mem_busy cycles tolerated before mem_timeout (1..65535)
//   CNT_W     width of the performance counters
//
// Ports:
//   clk, rst_n                    clock, synchronous active-low reset
//   IF_ID_Rs/Rt, IF_ID_UsesRs/Rt  source registers of the ID instruction
//   ID_EX_MemRead, ID_EX_DestReg  load flag / destination of the EX instruction
//   branch_taken                  branch in EX resolved taken this cycle
//   mem_busy                      data memory cannot complete this cycle
//   PC_Write .. MEM_WB_Write      pipeline register enables
//   IF_ID_Flush                   load a NOP into IF/ID
//   ID_EX_Bubble                  load a NOP into ID/EX
//   stall_cycles, flush_count     saturating performance counters
//   mem_timeout                   sticky watchdog flag
// -----------------------------------------------------------------------------
module hazard_control_unit #(
    parameter int unsigned MAX_WAIT = 64,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [2:0]       IF_ID_Rs,
    input  logic [2:0]       IF_ID_Rt,
    input  logic             IF_ID_UsesRs,
    input  logic             IF_ID_UsesRt,
    input  logic             ID_EX_MemRead,
    input  logic [2:0]       ID_EX_DestReg,
    input  logic             branch_taken,
    input  logic             mem_busy,
    output logic             PC_Write,
    output logic             IF_ID_Write,
    output logic             ID_EX_Write,
    output logic             EX_MEM_Write,
    output logic             MEM_WB_Write,
    output logic             IF_ID_Flush,
    output logic             ID_EX_Bubble,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count,
    output logic             mem_timeout
);

    localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

    localparam logic [1:0] ST_RUN        = 2'd0;
    localparam logic [1:0] ST_MEM_WAIT   = 2'd1;
    localparam logic [1:0] ST_FLUSH_PEND = 2'd2;

    logic [1:0]        state_q, state_d;
    logic              br_pend_q, br_pend_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              timeout_q, timeout_d;
    logic [CNT_W-1:0]  stall_q, stall_d;
    logic [CNT_W-1:0]  flush_q, flush_d;

    logic              lu;
    logic              freeze;
    logic              stall_inc;
    logic              flush_inc;

    // Register 0 is deliberately not special-cased.
    assign lu = ID_EX_MemRead &&
                ((IF_ID_UsesRs && (IF_ID_Rs == ID_EX_DestReg)) ||
                 (IF_ID_UsesRt && (IF_ID_Rt == ID_EX_DestReg)));

    // -------------------------------------------------------------------------
    // Control outputs and next state
    // -------------------------------------------------------------------------
    always_comb begin
        PC_Write     = 1'b1;
        IF_ID_Write  = 1'b1;
        ID_EX_Write  = 1'b1;
        EX_MEM_Write = 1'b1;
        MEM_WB_Write = 1'b1;
        IF_ID_Flush  = 1'b0;
        ID_EX_Bubble = 1'b0;
        freeze       = 1'b0;
        stall_inc    = 1'b0;
        flush_inc    = 1'b0;
        state_d      = state_q;
        br_pend_d    = br_pend_q;

        case (state_q)
            ST_RUN: begin
                if (mem_busy) begin
                    freeze    = 1'b1;
                    br_pend_d = branch_taken;
                    state_d   = ST_MEM_WAIT;
                end else if (branch_taken) begin
                    // The flush discards the dependent instruction, so a
                    // simultaneous load-use hazard needs no stall.
                    IF_ID_Flush  = 1'b1;
                    ID_EX_Bubble = 1'b1;
                    flush_inc    = 1'b1;
                end else if (lu) begin
                    PC_Write     = 1'b0;
                    IF_ID_Write  = 1'b0;
                    ID_EX_Bubble = 1'b1;
                    stall_inc    = 1'b1;
                end
            end

            ST_MEM_WAIT: begin
                stall_inc = 1'b1;
                if (mem_busy) begin
                    freeze    = 1'b1;
                    br_pend_d = br_pend_q | branch_taken;
                end else if (br_pend_q || branch_taken) begin
                    br_pend_d = 1'b1;
                    state_d   = ST_FLUSH_PEND;
                end else begin
                    br_pend_d = 1'b0;
                    state_d   = ST_RUN;
                end
            end

            ST_FLUSH_PEND: begin
                if (mem_busy) begin
                    // A new freeze wins; the deferred flush stays pending.
                    freeze    = 1'b1;
                    br_pend_d = 1'b1;
                    state_d   = ST_MEM_WAIT;
                end else begin
                    IF_ID_Flush  = 1'b1;
                    ID_EX_Bubble = 1'b1;
                    flush_inc    = 1'b1;
                    br_pend_d    = 1'b0;
                    state_d      = ST_RUN;
                end
            end

            default: begin
                br_pend_d = 1'b0;
                state_d   = ST_RUN;
            end
        endcase

        if (freeze) begin
            PC_Write     = 1'b0;
            IF_ID_Write  = 1'b0;
            ID_EX_Write  = 1'b0;
            EX_MEM_Write = 1'b0;
            MEM_WB_Write = 1'b0;
        end

        // Outputs are forced to pass-through while reset is held.
        if (!rst_n) begin
            PC_Write     = 1'b1;
            IF_ID_Write  = 1'b1;
            ID_EX_Write  = 1'b1;
            EX_MEM_Write = 1'b1;
            MEM_WB_Write = 1'b1;
            IF_ID_Flush  = 1'b0;
            ID_EX_Bubble = 1'b0;
        end
    end

    // -------------------------------------------------------------------------
    // Counters and watchdog
    // -------------------------------------------------------------------------
    always_comb begin
        stall_d = stall_q;
        flush_d = flush_q;
        if (stall_inc && (stall_q != '1)) begin
            stall_d = stall_q + CNT_W'(1);
        end
        if (flush_inc && (flush_q != '1)) begin
            flush_d = flush_q + CNT_W'(1);
        end

        wait_cnt_d = '0;
        if (mem_busy) begin
            wait_cnt_d = (wait_cnt_q == WAIT_MAX) ? wait_cnt_q
                                                  : wait_cnt_q + WAIT_W'(1);
        end
        timeout_d = timeout_q | (wait_cnt_q == WAIT_MAX);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_RUN;
            br_pend_q  <= 1'b0;
            wait_cnt_q <= '0;
            timeout_q  <= 1'b0;
            stall_q    <= '0;
            flush_q    <= '0;
        end else begin
            state_q    <= state_d;
            br_pend_q  <= br_pend_d;
            wait_cnt_q <= wait_cnt_d;
            timeout_q  <= timeout_d;
            stall_q    <= stall_d;
            flush_q    <= flush_d;
        end
    end

    assign stall_cycles = stall_q;
    assign flush_count  = flush_q;
    assign mem_timeout  = timeout_q;

endmodule

// File: tb/tb_hazard_control_unit.sv
// -----------------------------------------------------------------------------
// tb_hazard_control_unit
//
// Two instances share all inputs: dut_a uses 16-bit counters, dut_b 2-bit
// counters (to exercise saturation); both use MAX_WAIT = 4. A cycle-level
// behavioural model tracks "frozen", "flush owed" and "branch seen while
// frozen" flags plus unbounded counters clipped to each counter width.
// -----------------------------------------------------------------------------
module tb_hazard_control_unit;

    localparam int unsigned MAXW = 4;

    logic clk = 1'b0;
    logic rst_n;
    logic [2:0] IF_ID_Rs, IF_ID_Rt, ID_EX_DestReg;
    logic IF_ID_UsesRs, IF_ID_UsesRt, ID_EX_MemRead, branch_taken, mem_busy;

    logic pc_a, ifid_a, idex_a, exmem_a, memwb_a, fl_a, bub_a, tmo_a;
    logic pc_b, ifid_b, idex_b, exmem_b, memwb_b, fl_b, bub_b, tmo_b;
    logic [15:0] stall_a, flush_a;
    logic [1:0]  stall_b, flush_b;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    bit m_freeze, m_owe, m_pend, m_tmo;
    int m_run, m_stall, m_flush;

    always #5 clk = ~clk;

    hazard_control_unit #(.MAX_WAIT(MAXW), .CNT_W(16)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .IF_ID_Rs(IF_ID_Rs), .IF_ID_Rt(IF_ID_Rt),
        .IF_ID_UsesRs(IF_ID_UsesRs), .IF_ID_UsesRt(IF_ID_UsesRt),
        .ID_EX_MemRead(ID_EX_MemRead), .ID_EX_DestReg(ID_EX_DestReg),
        .branch_taken(branch_taken), .mem_busy(mem_busy),
        .PC_Write(pc_a), .IF_ID_Write(ifid_a), .ID_EX_Write(idex_a),
        .EX_MEM_Write(exmem_a), .MEM_WB_Write(memwb_a),
        .IF_ID_Flush(fl_a), .ID_EX_Bubble(bub_a),
        .stall_cycles(stall_a), .flush_count(flush_a), .mem_timeout(tmo_a)
    );

    hazard_control_unit #(.MAX_WAIT(MAXW), .CNT_W(2)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .IF_ID_Rs(IF_ID_Rs), .IF_ID_Rt(IF_ID_Rt),
        .IF_ID_UsesRs(IF_ID_UsesRs), .IF_ID_UsesRt(IF_ID_UsesRt),
        .ID_EX_MemRead(ID_EX_MemRead), .ID_EX_DestReg(ID_EX_DestReg),
        .branch_taken(branch_taken), .mem_busy(mem_busy),
        .PC_Write(pc_b), .IF_ID_Write(ifid_b), .ID_EX_Write(idex_b),
        .EX_MEM_Write(exmem_b), .MEM_WB_Write(memwb_b),
        .IF_ID_Flush(fl_b), .ID_EX_Bubble(bub_b),
        .stall_cycles(stall_b), .flush_count(flush_b), .mem_timeout(tmo_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int sat(input int v, input int maxv);
        return (v > maxv) ? maxv : v;
    endfunction

    // One clock cycle: drive at the falling edge, check #1 later, then
    // advance the model across the rising edge.
    task automatic step(input bit rst, input bit [2:0] rs, input bit [2:0] rt,
                        input bit urs, input bit urt, input bit mr,
                        input bit [2:0] dest, input bit br, input bit busy);
        bit       lu, e_fl, e_bub, inc_s, inc_f;
        bit [4:0] e_en;
        bit       n_freeze, n_owe, n_pend;

        rst_n = rst; IF_ID_Rs = rs; IF_ID_Rt = rt;
        IF_ID_UsesRs = urs; IF_ID_UsesRt = urt; ID_EX_MemRead = mr;
        ID_EX_DestReg = dest; branch_taken = br; mem_busy = busy;
        #1;

        lu = mr && ((urs && rs == dest) || (urt && rt == dest));
        e_en = 5'b11111; e_fl = 1'b0; e_bub = 1'b0; inc_s = 1'b0; inc_f = 1'b0;
        n_freeze = m_freeze; n_owe = m_owe; n_pend = m_pend;

        if (!rst) begin
            n_freeze = 1'b0; n_owe = 1'b0; n_pend = 1'b0;
        end else if (m_owe) begin
            if (busy) begin
                e_en = 5'b00000; n_freeze = 1'b1; n_owe = 1'b0; n_pend = 1'b1;
            end else begin
                e_fl = 1'b1; e_bub = 1'b1; inc_f = 1'b1; n_owe = 1'b0; n_pend = 1'b0;
            end
        end else if (m_freeze) begin
            inc_s = 1'b1;
            if (busy) begin
                e_en = 5'b00000; n_pend = m_pend | br;
            end else begin
                n_freeze = 1'b0; n_owe = m_pend | br; n_pend = 1'b0;
            end
        end else begin
            if (busy) begin
                e_en = 5'b00000; n_freeze = 1'b1; n_pend = br;
            end else if (br) begin
                e_fl = 1'b1; e_bub = 1'b1; inc_f = 1'b1;
            end else if (lu) begin
                e_en = 5'b00111; e_bub = 1'b1; inc_s = 1'b1;
            end
        end

        chk("enables_a", 32'({pc_a, ifid_a, idex_a, exmem_a, memwb_a}), 32'(e_en));
        chk("enables_b", 32'({pc_b, ifid_b, idex_b, exmem_b, memwb_b}), 32'(e_en));
        chk("flush_bubble_a", 32'({fl_a, bub_a}), 32'({e_fl, e_bub}));
        chk("flush_bubble_b", 32'({fl_b, bub_b}), 32'({e_fl, e_bub}));
        chk("stall_cycles_a", 32'(stall_a), 32'(sat(m_stall, 65535)));
        chk("stall_cycles_b", 32'(stall_b), 32'(sat(m_stall, 3)));
        chk("flush_count_a", 32'(flush_a), 32'(sat(m_flush, 65535)));
        chk("flush_count_b", 32'(flush_b), 32'(sat(m_flush, 3)));
        chk("mem_timeout_a", 32'(tmo_a), 32'(m_tmo));
        chk("mem_timeout_b", 32'(tmo_b), 32'(m_tmo));

        @(posedge clk);
        if (!rst) begin
            m_stall = 0; m_flush = 0; m_run = 0; m_tmo = 1'b0;
        end else begin
            if (inc_s) m_stall = sat(m_stall + 1, 70000);
            if (inc_f) m_flush = sat(m_flush + 1, 70000);
            m_tmo = m_tmo | (m_run >= int'(MAXW));
            m_run = busy ? sat(m_run + 1, 1000) : 0;
        end
        m_freeze = n_freeze; m_owe = n_owe; m_pend = n_pend;
        @(negedge clk);
    endtask

    task automatic idle(input bit busy, input bit br);
        step(1'b1, 3'd0, 3'd1, 1'b0, 1'b0, 1'b0, 3'd2, br, busy);
    endtask

    task automatic do_reset();
        step(1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0; IF_ID_Rs = '0; IF_ID_Rt = '0; IF_ID_UsesRs = 1'b0;
        IF_ID_UsesRt = 1'b0; ID_EX_MemRead = 1'b0; ID_EX_DestReg = '0;
        branch_taken = 1'b0; mem_busy = 1'b0;
        m_freeze = 1'b0; m_owe = 1'b0; m_pend = 1'b0; m_tmo = 1'b0;
        m_run = 0; m_stall = 0; m_flush = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);

        // Reset state
        do_reset();
        chk("reset_stall", 32'(stall_a), 32'd0);
        chk("reset_flush", 32'(flush_a), 32'd0);

        // Load-use on Rs, then the same with UsesRs = 0
        step(1'b1, 3'd3, 3'd0, 1'b1, 1'b0, 1'b1, 3'd3, 1'b0, 1'b0);
        chk("lu_rs_stall_count", 32'(stall_a), 32'd1);
        step(1'b1, 3'd3, 3'd0, 1'b0, 1'b0, 1'b1, 3'd3, 1'b0, 1'b0);
        // Rt match with and without a load in EX
        step(1'b1, 3'd1, 3'd7, 1'b0, 1'b1, 1'b1, 3'd7, 1'b0, 1'b0);
        step(1'b1, 3'd1, 3'd7, 1'b0, 1'b1, 1'b0, 3'd7, 1'b0, 1'b0);
        // Register 0 is not special
        step(1'b1, 3'd0, 3'd0, 1'b1, 1'b1, 1'b1, 3'd0, 1'b0, 1'b0);
        // Branch with a simultaneous load-use hazard: flush wins, no stall
        step(1'b1, 3'd5, 3'd0, 1'b1, 1'b0, 1'b1, 3'd5, 1'b1, 1'b0);
        chk("branch_no_stall", 32'(stall_a), 32'd3);
        chk("branch_flush", 32'(flush_a), 32'd1);

        // Freeze for 3 cycles with a branch in the 2nd, deferred flush
        do_reset();
        idle(1'b1, 1'b0);
        idle(1'b1, 1'b1);
        idle(1'b1, 1'b0);
        idle(1'b0, 1'b0);   // release
        idle(1'b0, 1'b0);   // deferred flush
        chk("freeze_stall_count", 32'(stall_a), 32'd3);
        chk("freeze_flush_count", 32'(flush_a), 32'd1);
        idle(1'b0, 1'b0);

        // Branch and busy together in RUN; busy again during the flush cycle
        idle(1'b1, 1'b1);
        idle(1'b0, 1'b0);
        idle(1'b1, 1'b0);
        idle(1'b0, 1'b0);
        idle(1'b0, 1'b0);
        idle(1'b0, 1'b0);

        // Watchdog: 5 busy cycles set it, it stays set after release
        do_reset();
        repeat (5) idle(1'b1, 1'b0);
        chk("watchdog_set", 32'(tmo_a), 32'd1);
        repeat (3) idle(1'b0, 1'b0);
        chk("watchdog_sticky", 32'(tmo_a), 32'd1);

        // Reset in the middle of a freeze with a pending branch
        idle(1'b1, 1'b1);
        idle(1'b1, 1'b0);
        step(1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b1);
        chk("reset_clears_timeout", 32'(tmo_a), 32'd0);
        chk("reset_clears_stall", 32'(stall_a), 32'd0);
        idle(1'b0, 1'b0);
        idle(1'b0, 1'b0);

        // Saturation: 5 consecutive load-use stalls
        do_reset();
        repeat (5) step(1'b1, 3'd4, 3'd0, 1'b1, 1'b0, 1'b1, 3'd4, 1'b0, 1'b0);
        chk("sat_stall_b", 32'(stall_b), 32'd3);
        chk("sat_stall_a", 32'(stall_a), 32'd5);

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 59) != 0),
                 3'($urandom_range(0, 3)), 3'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 3'($urandom_range(0, 3)),
                 ($urandom_range(0, 5) == 0), ($urandom_range(0, 3) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
